// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-ported dataMemory between two requesters.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 always win contention instead of round-robin.
module data_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic          memRead,
    output logic          memWrite,
    output logic [AW-1:0] address,
    output logic [DW-1:0] writeData,
    input  logic [DW-1:0] readData,
    output logic          busy,
    output logic [1:0]    dbg_state
);
    // Handshake: a requester raises req with stable we/addr/wdata and holds them until
    // its one-cycle ack; req is only sampled in IDLE, so holding it issues back-to-back transfers.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          gnt_id_q, gnt_id_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          win;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic          last_gnt_q, last_gnt_d;
`endif

    always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win = !p0_req;
`else
        // On contention the port that did not win last time goes next.
        if (p0_req && p1_req) win = !last_gnt_q;
        else                  win = !p0_req;
`endif
    end

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    gnt_id_d   = win;
                    we_d       = win ? p1_we    : p0_we;
                    addr_d     = win ? p1_addr  : p0_addr;
                    wdata_d    = win ? p1_wdata : p0_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    last_gnt_d = win;
`endif
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rdata_d = we_q ? '0 : readData;
                state_d = S_RESP;
            end
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gnt_id_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // All outputs decode registered state only, so they drop to zero the instant reset asserts.
    always_comb begin
        memRead   = (state_q == S_ACCESS) && !we_q;
        memWrite  = (state_q == S_ACCESS) && we_q;
        address   = (state_q == S_ACCESS) ? addr_q  : '0;
        writeData = (state_q == S_ACCESS) ? wdata_q : '0;
        p0_ack    = (state_q == S_RESP) && !gnt_id_q;
        p1_ack    = (state_q == S_RESP) && gnt_id_q;
        p0_rdata  = p0_ack ? rdata_q : '0;
        p1_rdata  = p1_ack ? rdata_q : '0;
        busy      = (state_q == S_ACCESS) || (state_q == S_RESP);
        dbg_state = state_q;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural data memory.
module tb_data_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        memRead, memWrite;
    logic [31:0] address, writeData, readData;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    data_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .memRead(memRead), .memWrite(memWrite), .address(address), .writeData(writeData),
        .readData(readData), .busy(busy), .dbg_state(dbg_state)
    );

    assign readData = mem[address[7:2]];
    always @(posedge clk) if (memWrite) mem[address[7:2]] <= writeData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_port;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        step(); step();
        reset = 1'b0;
        chk("rst_memRead", memRead, 0);
        chk("rst_memWrite", memWrite, 0);
        chk("rst_address", address, 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_acks", {p1_ack, p0_ack}, 0);
        chk("rst_rdata", p0_rdata | p1_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_no_ack", {p1_ack, p0_ack, busy}, 0);
        end

        // Port 0 write 16 to address 0
        p0_req = 1; p0_we = 1; p0_addr = 0; p0_wdata = 16;
        step();
        chk("wr_memWrite", memWrite, 1);
        chk("wr_memRead", memRead, 0);
        chk("wr_address", address, 0);
        chk("wr_writeData", writeData, 16);
        chk("wr_busy", busy, 1);
        chk("wr_no_early_ack", p0_ack, 0);
        step();
        chk("wr_ack", {p1_ack, p0_ack}, 2'b01);
        chk("wr_rdata_zero", p0_rdata, 0);
        chk("wr_memWrite_one_cycle", memWrite, 0);
        chk("wr_busy_resp", busy, 1);
        p0_req = 0;
        step();
        chk("wr_idle", {busy, p0_ack}, 0);

        // Port 0 read back address 0
        p0_req = 1; p0_we = 0; p0_wdata = 32'hDEAD;
        step();
        chk("rd_memRead", {memRead, memWrite}, 2'b10);
        chk("rd_address", address, 0);
        step();
        chk("rd_ack", {p1_ack, p0_ack}, 2'b01);
        chk("rd_rdata", p0_rdata, 16);
        p0_req = 0;
        step();

        // Contention from reset: p0 write 0xA5 @4 wins, then p1 reads it
        reset = 1; #2; reset = 0;
        p0_req = 1; p0_we = 1; p0_addr = 4; p0_wdata = 32'hA5;
        p1_req = 1; p1_we = 0; p1_addr = 4; p1_wdata = 0;
        step();
        chk("ct_first_write", {memWrite, memRead}, 2'b10);
        chk("ct_first_addr", address, 4);
        chk("ct_first_data", writeData, 32'hA5);
        step();
        chk("ct_first_ack", {p1_ack, p0_ack}, 2'b01);
        p0_req = 0;
        step();
        step();
        chk("ct_second_read", {memWrite, memRead}, 2'b01);
        chk("ct_second_addr", address, 4);
        step();
        chk("ct_second_ack", {p1_ack, p0_ack}, 2'b10);
        chk("ct_second_rdata", p1_rdata, 32'hA5);
        p1_req = 0;
        step();

        // Sustained double requests: last grant was port 1
        p0_req = 1; p0_we = 0; p0_addr = 0;
        p1_req = 1; p1_we = 0; p1_addr = 4;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_port = 0;
`else
            exp_port = i % 2;
`endif
            step();
            step();
            chk("alt_ack", {p1_ack, p0_ack}, exp_port[0] ? 2'b10 : 2'b01);
            chk("alt_rdata", p0_rdata | p1_rdata, exp_port[0] ? 32'hA5 : 32'd16);
            step();
        end
        p0_req = 0;
        step(); step();
        chk("p1_after_p0_drops", {p1_ack, p0_ack}, 2'b10);
        p1_req = 0;
        step();

        // Back-to-back: p1 holds req for 3 transfers
        p1_req = 1; p1_we = 0; p1_addr = 4;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("b2b_ack_timing", p1_ack, (k % 3 == 1) ? 1 : 0);
            chk("b2b_excl", memRead & memWrite, 0);
            if (k == 7) p1_req = 0;
        end
        step();
        chk("b2b_idle", {busy, p1_ack}, 0);

        // Reset during ACCESS of a p0 write
        p0_req = 1; p0_we = 1; p0_addr = 8; p0_wdata = 32'h55;
        step();
        chk("ra_access", memWrite, 1);
        #2 reset = 1;
        #1;
        chk("ra_memWrite", {memWrite, memRead}, 0);
        chk("ra_address", address, 0);
        chk("ra_writeData", writeData, 0);
        chk("ra_busy", busy, 0);
        chk("ra_state", dbg_state, 0);
        p0_req = 0;
        step();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ra_no_ack", {p1_ack, p0_ack, busy}, 0);
        end
        chk("ra_state_idle", dbg_state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
